fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V integer pipeline. Holds the fetch PC and issues in-order word requests to instruction memory with up to two in flight. Buffers returned instructions, with their PCs, in a 2-entry queue for the decode stage. Consumes the execute-stage redirect (`branch_true` / `branched_pc`) to steer fetch, flush buffered instructions and drop stale memory responses.

---
 rtl/rv_pkg.sv | 18 +
 rtl/sync_fifo2.sv | 55 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 pipeline constants and inter-stage types.
// Imported by the fetch stage and its helper FIFO.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

    localparam if_entry_t IQ_RESET = '{pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with flush; head is visible on dout.
// Storage keeps its last written contents when the FIFO is empty.
module sync_fifo2 #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= RESET_VAL;
            mem[1] <= RESET_VAL;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count
                   + {1'b0, do_push}
                   - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, two-deep request credit, decode queue.
// Execute redirects flush the queue and drop stale memory responses.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_true,
    input  logic [XLEN-1:0] branched_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      drop_cnt;

    logic [1:0]      pq_count;
    logic [1:0]      iq_count;
    logic            pq_full;
    logic            pq_empty;
    logic            iq_full;
    logic            iq_empty;
    logic [XLEN-1:0] pq_head;
    if_entry_t       iq_in;
    if_entry_t       iq_head;

    logic [2:0]      occ;
    logic [1:0]      live_after;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            iq_pop;
    logic            unused_bits;

    assign occ = {1'b0, pq_count}
               + {1'b0, iq_count};

    assign if_valid = !iq_empty;
    assign iq_pop   = if_valid && if_ready;
    assign if_pc    = iq_head.pc;
    assign if_instr = iq_head.instr;

    // A head leaving for decode this cycle frees its slot for a new request.
    assign imem_req_valid = rst_n && !branch_true
                         && ((occ - {2'b00, iq_pop}) < 3'd2);
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req_valid && imem_req_ready;

    assign rsp_keep = imem_rsp_valid && !branch_true
                   && (drop_cnt == 2'd0);
    assign rsp_drop = imem_rsp_valid && (drop_cnt != 2'd0);
    assign iq_in    = '{pc: pq_head, instr: imem_rsp_data};

    assign live_after = pq_count
                      - {1'b0, imem_rsp_valid && !pq_empty};
    assign redirect_pc = {branched_pc[XLEN-1:2], 2'b00};

    assign unused_bits = ^{pq_full, iq_full, branched_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
            drop_cnt <= 2'd0;
        end else if (branch_true) begin
            fetch_pc <= redirect_pc;
            drop_cnt <= live_after;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

    sync_fifo2 #(
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_pq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (imem_rsp_valid),
        .clear (1'b0),
        .din   (fetch_pc),
        .dout  (pq_head),
        .full  (pq_full),
        .empty (pq_empty),
        .count (pq_count)
    );

    sync_fifo2 #(
        .WIDTH     (2 * XLEN),
        .RESET_VAL (IQ_RESET)
    ) u_iq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (iq_pop),
        .clear (branch_true),
        .din   (iq_in),
        .dout  (iq_head),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, scoreboard monitor,
// and a second instance exercising a wrapping reset PC.
module tb_fetch_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        branch_true = 1'b0;
    logic [31:0] branched_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        r2_req_valid;
    logic [31:0] r2_addr;
    logic        r2_rsp_valid = 1'b0;
    logic [31:0] r2_rsp_data = '0;
    logic        r2_if_valid;
    logic [31:0] r2_if_instr;
    logic [31:0] r2_if_pc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;
    int fire_cnt = 0;
    int handoff_cnt = 0;
    int first_fire_cyc = -1;
    int first_ho_cyc = -1;
    int last_ho_cyc = 0;
    logic [31:0] first_ho_pc = '0;
    logic [31:0] last_ho_pc = '0;
    logic [31:0] exp_fetch = '0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] mq[$];
    int          md[$];

    logic [31:0] r2_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC,
                                32'h0000_0000, 32'h0000_0004};
    int r2_n = 0;
    int r2_h = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_true    (branch_true),
        .branched_pc    (branched_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_true    (1'b0),
        .branched_pc    (32'h0),
        .imem_req_valid (r2_req_valid),
        .imem_req_ready (1'b1),
        .imem_addr      (r2_addr),
        .imem_rsp_valid (r2_rsp_valid),
        .imem_rsp_data  (r2_rsp_data),
        .if_valid       (r2_if_valid),
        .if_ready       (1'b1),
        .if_instr       (r2_if_instr),
        .if_pc          (r2_if_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_handoff(input string name,
                                input logic [31:0] exp_pc,
                                input int rcyc);
        int  h;
        bit  got;
        h = handoff_cnt;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1;
            if (handoff_cnt != h) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s: no handoff within 30 cycles", name);
        end else begin
            check(name, last_ho_pc, exp_pc);
            check({name, "_lat"}, 32'(last_ho_cyc - rcyc >= 3), 32'd1);
        end
    endtask

    // In-order instruction memory with programmable latency.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back(imem_addr);
                md.push_back(cyc + mem_lat);
            end
            @(posedge clk);
            #1;
            if (md.size() > 0 && md[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mq.pop_front());
                void'(md.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: request addresses and decode handoffs.
    initial begin
        logic [31:0] p;
        wait (rst_n == 1'b0);
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            if (branch_true) begin
                check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
                exp_pc_q.delete();
                exp_fetch = {branched_pc[31:2], 2'b00};
            end else begin
                if (if_valid && if_ready) begin
                    handoff_cnt++;
                    last_ho_pc  = if_pc;
                    last_ho_cyc = cyc;
                    if (first_ho_cyc < 0) begin
                        first_ho_cyc = cyc;
                        first_ho_pc  = if_pc;
                    end
                    if (exp_pc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_handoff: got pc %h expected none", if_pc);
                    end else begin
                        p = exp_pc_q.pop_front();
                        check("if_pc", if_pc, p);
                        check("if_instr", if_instr, instr_of(p));
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    fire_cnt++;
                    if (first_fire_cyc < 0) first_fire_cyc = cyc;
                    check("imem_addr", imem_addr, exp_fetch);
                    exp_pc_q.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    // Second instance: 1-cycle memory, checks the wrapping address stream.
    initial begin
        logic        f;
        logic [31:0] fa;
        wait (rst_n == 1'b0);
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            f  = r2_req_valid;
            fa = r2_addr;
            if (r2_if_valid && r2_h < 4) begin
                check("r2_if_pc", r2_if_pc, r2_exp[r2_h]);
                check("r2_if_instr", r2_if_instr, instr_of(r2_exp[r2_h]));
                r2_h++;
            end
            if (f && r2_n < 4) begin
                check("r2_addr", r2_addr, r2_exp[r2_n]);
                r2_n++;
            end
            @(posedge clk);
            #1;
            r2_rsp_valid = f;
            r2_rsp_data  = instr_of(fa);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h0;
        int          f0;
        int          rcyc;
        bit          found;
        logic [31:0] a0;

        #1 rst_n = 1'b0;
        #3;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, NOP_INSTR);
        check("rst_if_pc", if_pc, 32'h0);

        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_addr, 32'h0);

        tick(6);
        h0 = handoff_cnt;
        f0 = fire_cnt;
        tick(8);
        check("steady_fires", 32'(fire_cnt - f0), 32'd8);
        check("steady_handoffs", 32'(handoff_cnt - h0), 32'd8);
        check("first_latency", 32'(first_ho_cyc - first_fire_cyc), 32'd2);
        check("first_pc", first_ho_pc, 32'h0);

        if_ready = 1'b0;
        h0 = handoff_cnt;
        f0 = fire_cnt;
        @(negedge clk);
        a0 = imem_addr;
        tick(4);
        @(negedge clk);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        check("stall_addr", imem_addr, a0);
        check("stall_fires", 32'(fire_cnt - f0), 32'd0);
        check("stall_handoffs", 32'(handoff_cnt - h0), 32'd0);
        tick(1);
        if_ready = 1'b1;

        tick(4);
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!imem_req_valid && !if_valid && !imem_rsp_valid) found = 1'b1;
        end
        check("two_outstanding", 32'(found), 32'd1);
        tick(1);
        branch_true = 1'b1;
        branched_pc = 32'h0000_0103;
        rcyc = cyc;
        tick(1);
        branch_true = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        check("redir_valid", 32'(imem_req_valid), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        wait_handoff("redir_first_pc", 32'h0000_0100, rcyc);

        tick(6);
        branch_true = 1'b1;
        branched_pc = 32'h0000_0200;
        @(negedge clk);
        check("same_cyc_rsp", 32'(imem_rsp_valid), 32'd1);
        check("same_cyc_if_valid", 32'(if_valid), 32'd1);
        check("same_cyc_no_req", 32'(imem_req_valid), 32'd0);
        tick(1);
        branch_true = 1'b0;
        @(negedge clk);
        check("flushed_if_valid", 32'(if_valid), 32'd0);
        check("flushed_addr", imem_addr, 32'h0000_0200);

        mem_lat = 2;
        tick(6);
        imem_req_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid) found = 1'b1;
        end
        check("stall2_valid_seen", 32'(found), 32'd1);
        a0 = imem_addr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall2_valid", 32'(imem_req_valid), 32'd1);
            check("stall2_addr", imem_addr, a0);
        end
        tick(1);
        imem_req_ready = 1'b1;
        tick(1);
        branch_true = 1'b1;
        branched_pc = 32'h0000_0300;
        tick(1);
        branched_pc = 32'h0000_0402;
        rcyc = cyc;
        tick(1);
        branch_true = 1'b0;
        @(negedge clk);
        check("redir2_addr", imem_addr, 32'h0000_0400);
        wait_handoff("redir2_first_pc", 32'h0000_0400, rcyc);

        tick(4);
        imem_req_ready = 1'b0;
        tick(10);
        check("scoreboard_drained", 32'(exp_pc_q.size()), 32'd0);
        check("r2_addr_count", 32'(r2_n), 32'd4);
        check("r2_handoff_count", 32'(r2_h), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
